// File: rtl/delay_sequence_detector.sv
// delay_sequence_detector
// Watches the a/b handshake pair and recognises "a, then b exactly DELAY
// cycles later". Each recognised pair produces a one-cycle match pulse and
// bumps a saturating counter. A b with no a DELAY edges earlier raises a
// sticky orphan flag. A synchronous clear wipes all history and flags.

module delay_sequence_detector #(
  parameter int DELAY        = 1,
  parameter int COUNT_W      = 8,
  parameter bit CHECK_ORPHAN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               a,
  input  logic               b,
  output logic               match,
  output logic               pending,
  output logic [COUNT_W-1:0] match_count,
  output logic               count_sat,
  output logic               orphan_b
);

  // The shift register below is only meaningful for a DELAY of 1..16.
  generate
    if (DELAY < 1 || DELAY > 16) begin : g_bad_delay
      $error("delay_sequence_detector: DELAY must lie in 1..16");
    end
  endgenerate

  logic [DELAY-1:0]   hist_q;
  logic [DELAY-1:0]   hist_d;
  logic               match_q;
  logic               match_d;
  logic               pending_q;
  logic               pending_d;
  logic [COUNT_W-1:0] match_count_q;
  logic [COUNT_W-1:0] match_count_d;
  logic               count_sat_q;
  logic               count_sat_d;
  logic               orphan_q;
  logic               orphan_d;
  logic               start_due;
  logic               hit;

  // The oldest history bit holds the a sampled exactly DELAY edges ago.
  // A b on the same edge as an a only sees the old history, so an a can
  // never complete its own window.
  always_comb begin
    start_due = hist_q[DELAY-1];
    hit       = b && start_due && !clear;
  end

  // Shift a into the history; clear empties it and drops the a sampled now.
  always_comb begin
    hist_d    = '0;
    hist_d[0] = a;
    for (int k = 1; k < DELAY; k++) begin
      hist_d[k] = hist_q[k-1];
    end
    if (clear) begin
      hist_d = '0;
    end
  end

  // Pending reflects the history after this edge's shift: any a still
  // travelling toward its b slot keeps it high.
  always_comb begin
    pending_d = |hist_d;
  end

  // Match pulse follows the hit by one register stage.
  always_comb begin
    match_d = hit;
  end

  // Counter saturates at all-ones; the saturation flag tracks the new value
  // so both registers update together.
  always_comb begin
    match_count_d = match_count_q;
    if (clear) begin
      match_count_d = '0;
    end else if (hit && !(&match_count_q)) begin
      match_count_d = match_count_q + 1'b1;
    end
    count_sat_d = &match_count_d;
  end

  // Orphan flag is sticky until reset or clear; compiled out when disabled.
  always_comb begin
    orphan_d = orphan_q;
    if (clear) begin
      orphan_d = 1'b0;
    end else if (CHECK_ORPHAN && b && !start_due) begin
      orphan_d = 1'b1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q        <= '0;
      match_q       <= 1'b0;
      pending_q     <= 1'b0;
      match_count_q <= '0;
      count_sat_q   <= 1'b0;
      orphan_q      <= 1'b0;
    end else begin
      hist_q        <= hist_d;
      match_q       <= match_d;
      pending_q     <= pending_d;
      match_count_q <= match_count_d;
      count_sat_q   <= count_sat_d;
      orphan_q      <= orphan_d;
    end
  end

  assign match       = match_q;
  assign pending     = pending_q;
  assign match_count = match_count_q;
  assign count_sat   = count_sat_q;
  assign orphan_b    = orphan_q;

endmodule

// File: tb/tb_delay_sequence_detector.sv
// tb_delay_sequence_detector
// Five detector instances with different DELAY/COUNT_W/CHECK_ORPHAN settings
// share one a/b/clear/rst stimulus. A queue-based model of the a history
// predicts every output of every instance each cycle; a vector table and a
// few directed sequences add constant expectations for specific scenarios.

module tb_delay_sequence_detector;

  localparam int NI = 5;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  logic a;
  logic b;

  logic       m0, m1, m2, m3, m4;
  logic       p0, p1, p2, p3, p4;
  logic [1:0] c0;
  logic [7:0] c1, c2, c3;
  logic [2:0] c4;
  logic       s0, s1, s2, s3, s4;
  logic       o0, o1, o2, o3, o4;

  logic       m_arr [NI];
  logic       p_arr [NI];
  logic [7:0] c_arr [NI];
  logic       s_arr [NI];
  logic       o_arr [NI];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  delay_sequence_detector #(.DELAY(1),  .COUNT_W(2), .CHECK_ORPHAN(1'b1)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .a(a), .b(b), .match(m0),
    .pending(p0), .match_count(c0), .count_sat(s0), .orphan_b(o0));
  delay_sequence_detector #(.DELAY(2),  .COUNT_W(8), .CHECK_ORPHAN(1'b1)) u2 (
    .clk(clk), .rst(rst), .clear(clear), .a(a), .b(b), .match(m1),
    .pending(p1), .match_count(c1), .count_sat(s1), .orphan_b(o1));
  delay_sequence_detector #(.DELAY(3),  .COUNT_W(8), .CHECK_ORPHAN(1'b1)) u3 (
    .clk(clk), .rst(rst), .clear(clear), .a(a), .b(b), .match(m2),
    .pending(p2), .match_count(c2), .count_sat(s2), .orphan_b(o2));
  delay_sequence_detector #(.DELAY(4),  .COUNT_W(8), .CHECK_ORPHAN(1'b1)) u4 (
    .clk(clk), .rst(rst), .clear(clear), .a(a), .b(b), .match(m3),
    .pending(p3), .match_count(c3), .count_sat(s3), .orphan_b(o3));
  delay_sequence_detector #(.DELAY(16), .COUNT_W(3), .CHECK_ORPHAN(1'b0)) u5 (
    .clk(clk), .rst(rst), .clear(clear), .a(a), .b(b), .match(m4),
    .pending(p4), .match_count(c4), .count_sat(s4), .orphan_b(o4));

  assign m_arr[0] = m0;  assign m_arr[1] = m1;  assign m_arr[2] = m2;
  assign m_arr[3] = m3;  assign m_arr[4] = m4;
  assign p_arr[0] = p0;  assign p_arr[1] = p1;  assign p_arr[2] = p2;
  assign p_arr[3] = p3;  assign p_arr[4] = p4;
  assign c_arr[0] = {6'd0, c0};
  assign c_arr[1] = c1;  assign c_arr[2] = c2;  assign c_arr[3] = c3;
  assign c_arr[4] = {5'd0, c4};
  assign s_arr[0] = s0;  assign s_arr[1] = s1;  assign s_arr[2] = s2;
  assign s_arr[3] = s3;  assign s_arr[4] = s4;
  assign o_arr[0] = o0;  assign o_arr[1] = o1;  assign o_arr[2] = o2;
  assign o_arr[3] = o3;  assign o_arr[4] = o4;

  // Reference model: a log of every a sampled since the last reset/clear.
  int dly   [NI] = '{1, 2, 3, 4, 16};
  int cwid  [NI] = '{2, 8, 8, 8, 3};
  bit chk   [NI] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  bit a_log [$];
  bit exp_m [NI];
  int exp_c [NI];
  bit exp_o [NI];
  bit exp_p [NI];

  function automatic void modelReset();
    a_log.delete();
    for (int i = 0; i < NI; i++) begin
      exp_m[i] = 1'b0;
      exp_c[i] = 0;
      exp_o[i] = 1'b0;
      exp_p[i] = 1'b0;
    end
  endfunction

  function automatic void modelStep(bit va, bit vb, bit vclr);
    int sz;
    if (vclr) begin
      modelReset();
      return;
    end
    sz = a_log.size();
    for (int i = 0; i < NI; i++) begin
      bit started;
      started  = (sz >= dly[i]) && a_log[sz - dly[i]];
      exp_m[i] = vb && started;
      if (exp_m[i] && exp_c[i] < (1 << cwid[i]) - 1) exp_c[i]++;
      if (chk[i] && vb && !started) exp_o[i] = 1'b1;
    end
    a_log.push_back(va);
    if (a_log.size() > 16) void'(a_log.pop_front());
    sz = a_log.size();
    for (int i = 0; i < NI; i++) begin
      exp_p[i] = 1'b0;
      for (int k = 1; k <= dly[i]; k++) begin
        if (sz >= k && a_log[sz - k]) exp_p[i] = 1'b1;
      end
    end
  endfunction

  task automatic checkVal(input string nm, input int act, input int req);
    n_assert++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic checkOutput();
    for (int i = 0; i < NI; i++) begin
      checkVal($sformatf("u%0d.match", i + 1), int'(m_arr[i]), int'(exp_m[i]));
      checkVal($sformatf("u%0d.pending", i + 1), int'(p_arr[i]), int'(exp_p[i]));
      checkVal($sformatf("u%0d.match_count", i + 1), int'(c_arr[i]), exp_c[i]);
      checkVal($sformatf("u%0d.count_sat", i + 1), int'(s_arr[i]),
               int'(exp_c[i] == (1 << cwid[i]) - 1));
      checkVal($sformatf("u%0d.orphan_b", i + 1), int'(o_arr[i]), int'(exp_o[i]));
    end
  endtask

  // Drive one edge worth of inputs, advance the model, compare 1ns later.
  task automatic applyStimulus(input bit va, input bit vb, input bit vclr);
    a     = va;
    b     = vb;
    clear = vclr;
    @(posedge clk);
    modelStep(va, vb, vclr);
    #1;
    checkOutput();
  endtask

  // Pulse rst between edges and confirm outputs drop before any clock edge.
  task automatic asyncReset();
    a     = 1'b0;
    b     = 1'b0;
    clear = 1'b0;
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput();
    #1 rst = 1'b0;
  endtask

  typedef struct {
    bit va;
    bit vb;
    bit vclr;
    bit m;
    int c;
    bit o;
    bit p;
  } vec_t;

  vec_t tbl [17];

  initial begin
    // DELAY=3 (u3) vectors: orphan then late match, clear, overlapping starts.
    tbl[0]  = '{0, 0, 1, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 0, 1};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 1};
    tbl[7]  = '{0, 1, 0, 0, 0, 1, 1};
    tbl[8]  = '{0, 1, 0, 1, 1, 1, 0};
    tbl[9]  = '{0, 0, 1, 0, 0, 0, 0};
    tbl[10] = '{1, 0, 0, 0, 0, 0, 1};
    tbl[11] = '{1, 0, 0, 0, 0, 0, 1};
    tbl[12] = '{1, 0, 0, 0, 0, 0, 1};
    tbl[13] = '{0, 1, 0, 1, 1, 0, 1};
    tbl[14] = '{0, 1, 0, 1, 2, 0, 1};
    tbl[15] = '{0, 1, 0, 1, 3, 0, 0};
    tbl[16] = '{0, 0, 0, 0, 3, 0, 0};

    rst   = 1'b1;
    a     = 1'b0;
    b     = 1'b0;
    clear = 1'b0;
    #2;
    modelReset();
    checkOutput();
    #10 rst = 1'b0;

    for (int r = 0; r < 17; r++) begin
      applyStimulus(tbl[r].va, tbl[r].vb, tbl[r].vclr);
      checkVal($sformatf("tbl[%0d].match", r), int'(m2), int'(tbl[r].m));
      checkVal($sformatf("tbl[%0d].count", r), int'(c2), tbl[r].c);
      checkVal($sformatf("tbl[%0d].orphan", r), int'(o2), int'(tbl[r].o));
      checkVal($sformatf("tbl[%0d].pending", r), int'(p2), int'(tbl[r].p));
    end

    // DELAY=1: a then b on the next edge gives a single pulse.
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    checkVal("d1.match_on", int'(m0), 1);
    checkVal("d1.count", int'(c0), 1);
    checkVal("d1.orphan", int'(o0), 0);
    applyStimulus(0, 0, 0);
    checkVal("d1.match_off", int'(m0), 0);

    // COUNT_W=2 saturation with a and b held high.
    applyStimulus(0, 0, 1);
    applyStimulus(1, 1, 0);
    checkVal("sat.first_orphan", int'(o0), 1);
    checkVal("sat.count0", int'(c0), 0);
    for (int k = 0; k < 5; k++) begin
      int want;
      want = (k < 3) ? k + 1 : 3;
      applyStimulus(1, 1, 0);
      checkVal($sformatf("sat.count%0d", k + 1), int'(c0), want);
      checkVal($sformatf("sat.flag%0d", k + 1), int'(s0), int'(want == 3));
      checkVal($sformatf("sat.match%0d", k + 1), int'(m0), 1);
    end

    // DELAY=4: reset mid-window discards the in-flight start.
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    checkVal("rstwin.pending_before", int'(p3), 1);
    asyncReset();
    checkVal("rstwin.pending_after", int'(p3), 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    checkVal("rstwin.match", int'(m3), 0);
    checkVal("rstwin.orphan", int'(o3), 1);

    // DELAY=2: clear between a and its b slot drops the start.
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 1);
    checkVal("clr.pending", int'(p1), 0);
    applyStimulus(0, 1, 0);
    checkVal("clr.match", int'(m1), 0);
    checkVal("clr.count", int'(c1), 0);
    checkVal("clr.orphan", int'(o1), 1);

    // Randomised traffic with occasional clears and asynchronous resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        asyncReset();
      end else begin
        applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                      $urandom_range(0, 39) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
